sm_control_unit: RTL and testbench
==================================

Name: sm_control_unit

Overview:
Control unit for the single-cycle ARM-subset datapath. It decodes the fetched instruction and drives every datapath select and enable.
- Holds the architectural NZCV flag register and evaluates condition codes against it.
- Sequences a two-state handshake with data memory so that LDR/STR can take more than one cycle.
- Sits beside the datapath in the top-level core. It receives the instruction word and ALUFlags, and returns the control vector plus a PC enable.

Parameters:
MEM_WAIT_MAX, 15, maximum wait cycles before timeout; used only when SM_MEM_WAIT_EN is defined; counter width is $clog2(MEM_WAIT_MAX+1).

Ports:
clk  in  1  core clock
rst_p  in  1  asynchronous active-high reset
instr  in  32  current instruction (instructionMemory_data)
alu_flags  in  4  ALU flags {N,Z,C,V} from datapath
mem_ack  in  1  data memory completes the access this cycle
RegSrc  out  2  [0]=1 selects R15 as RA1 (branch); [1]=1 selects Rd as RA2 (STR)
RegWrite  out  1  register file write enable
ImmSrc  out  2  00 DP imm8, 01 mem imm12, 10 branch imm24
ALUSrc  out  1  1 selects ExtImm as SrcB
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
MemtoReg  out  1  1 selects read data as Result
PCSrc  out  1  1 loads PC from Result
MemWrite  out  1  data memory write strobe
mem_req  out  1  data memory access request
pc_en  out  1  PC register enable
writeData3Src  out  1  1 = BL link (A3=R14, WD3=PC+4)
srcASrc  out  1  1 forces SrcA to 0 (MOV)
flags  out  4  registered NZCV
mem_err  out  1  one-cycle pulse on memory timeout (SM_MEM_WAIT_EN only; else 0)

Behaviour:
Decode: op=instr[27:26], cond=instr[31:28], Rd=instr[15:12].

op 00, data-processing:
- Immediate form (I=instr[25]): ALUSrc=1, ImmSrc=00.
- cmd=instr[24:21] mapping:
  - 0100 ADD→00
  - 0010 SUB→01
  - 0000 AND→10
  - 1100 ORR→11
  - 1010 CMP→01, no RegWrite
  - 1101 MOV→00 with srcASrc=1
  - any other cmd: no writes.
- S=instr[20] is the flag-write enable.
  - ADD/SUB/CMP update NZCV.
  - AND/ORR/MOV update N,Z only.
  - CMP always updates flags.

op 01, memory:
- ALUSrc=1, ImmSrc=01.
- ALUControl=00 when U=instr[23]=1, 01 when U=0.
- L=instr[20]=1 is LDR: MemtoReg=1, RegWrite at completion.
- L=0 is STR: RegSrc[1]=1, MemWrite=1.

op 10, branch:
- RegSrc[0]=1, ALUSrc=1, ImmSrc=10, ALUControl=00, PCSrc=1.
- instr[24]=1 is BL: additionally writeData3Src=1, RegWrite=1.

op 11: no-op (all enables 0).

PCSrc is also asserted when Rd=15 and the instruction writes a register (DP result or LDR).

Condition codes:
- Full ARM set EQ..LE and AL, evaluated against the registered flags.
- cond=1111 never passes.
- When cond fails: RegWrite, MemWrite, mem_req, PCSrc and flag write are all forced 0, and pc_en=1.

FSM, states EXEC and WAIT; reset state EXEC:
- EXEC, passing LDR/STR: mem_req=1.
  - mem_ack=1 → instruction retires this cycle; stay in EXEC.
  - mem_ack=0 → pc_en=0, RegWrite=0, no flag write; go to WAIT.
- WAIT: mem_req=1, MemWrite held for STR, pc_en=0, RegWrite=0.
  - mem_ack=1 → pc_en=1, RegWrite for LDR, PCSrc if Rd=15; go to EXEC.
- Any non-memory instruction in EXEC retires in one cycle with pc_en=1.
- instr is stable during WAIT because the PC is held.

Flag register:
- Updates on the clock edge of the retiring cycle only, i.e. pc_en=1, cond passed and flag-write enabled.
- Loads the alu_flags fields selected above.

Reset (asynchronous, effective immediately including mid-WAIT):
- state=EXEC, flags=0000.
- While rst_p=1, RegWrite, MemWrite, mem_req, PCSrc and mem_err are forced 0, and pc_en=0.

Optional Feature:
SM_MEM_WAIT_EN

Defined:
- WAIT counts cycles from 1.
- On reaching MEM_WAIT_MAX without mem_ack:
  - mem_err pulses for 1 cycle and the access is abandoned.
  - LDR writes nothing; pc_en=1; return to EXEC.
- The counter clears on entry to WAIT and on reset.

Not defined:
- No counter; WAIT lasts until mem_ack.
- mem_err is tied 0.

Decomposition:
Package sm_ctrl_pkg holds:
- cond_t enum (EQ..AL, NV)
- op_t enum (DP, MEM, BR)
- cmd constants (ADD, SUB, AND, ORR, CMP, MOV)
- ALUControl and ImmSrc encodings
- state_t {EXEC, WAIT}

One sub-module: sm_cond_check, a combinational evaluator taking (cond, flags) and producing cond_pass.

Test Plan:
- ADDS R1,R2,#5 (0xE2921005), alu_flags=0100 → RegWrite=1, ALUSrc=1, ALUControl=00, ImmSrc=00, pc_en=1; flags=0100 after the edge.
- Flags Z=1, BEQ 0x0A000002 → PCSrc=1, RegSrc=01, ImmSrc=10. Flags Z=0, same instruction → PCSrc=0, RegWrite=0, pc_en=1.
- BL 0xEB000004 → writeData3Src=1, RegWrite=1, PCSrc=1, ALUSrc=1.
- LDR R0,[R1,#4] (0xE5910004) with mem_ack low for 3 cycles, high on the 4th:
  - mem_req=1 for 4 cycles; pc_en=0 and RegWrite=0 for the first 3.
  - 4th cycle: RegWrite=1, MemtoReg=1, pc_en=1.
- MOV R3,#0xFF (0xE3A030FF) → srcASrc=1, ALUControl=00, RegWrite=1, flags unchanged. Then CMP R1,#0 (0xE3510000) with alu_flags=0110 → RegWrite=0, ALUControl=01, flags=0110.
- rst_p pulsed during WAIT of STR 0xE5810000 → mem_req and MemWrite drop immediately; flags=0000. After release, state=EXEC and mem_req re-asserts. With SM_MEM_WAIT_EN and MEM_WAIT_MAX=15 and no ack, mem_err pulses once after 15 WAIT cycles.

Source files
------------

// File: rtl/sm_ctrl_pkg.sv
// Shared encodings for the ARM-subset control unit.
// Condition codes, opcodes, DP commands, select encodings and FSM states.
package sm_ctrl_pkg;

  typedef enum logic [3:0] {
    EQ, NE, CS, CC, MI, PL, VS, VC,
    HI, LS, GE, LT, GT, LE, AL, NV
  } cond_t;

  typedef enum logic [1:0] {
    DP  = 2'b00,
    MEM = 2'b01,
    BR  = 2'b10
  } op_t;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [3:0] PC_REG = 4'd15;

  typedef enum logic {
    EXEC = 1'b0,
    WAIT = 1'b1
  } state_t;

  function automatic logic cmd_is_arith(input logic [3:0] c);
    return (c == CMD_ADD) || (c == CMD_SUB) || (c == CMD_CMP);
  endfunction

endpackage

// File: rtl/sm_control_unit_cond.sv
// Combinational ARM condition-code evaluator.
// NV (1111) never passes.
module sm_cond_check
  import sm_ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign {n, z, c, v} = flags_i;

  always_comb begin
    pass_o = 1'b0;
    unique case (cond_t'(cond_i))
      EQ: pass_o = z;
      NE: pass_o = ~z;
      CS: pass_o = c;
      CC: pass_o = ~c;
      MI: pass_o = n;
      PL: pass_o = ~n;
      VS: pass_o = v;
      VC: pass_o = ~v;
      HI: pass_o = c & ~z;
      LS: pass_o = ~c | z;
      GE: pass_o = (n == v);
      LT: pass_o = (n != v);
      GT: pass_o = ~z & (n == v);
      LE: pass_o = z | (n != v);
      AL: pass_o = 1'b1;
      NV: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/sm_control_unit.sv
// Decode, NZCV flag register and EXEC/WAIT memory handshake.
// Define SM_MEM_WAIT_EN to enable the WAIT timeout counter and mem_err.
module sm_control_unit
  import sm_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_p,
  input  logic [31:0] instr,
  input  logic [3:0]  alu_flags,
  input  logic        mem_ack,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrc,
  output logic [1:0]  ALUControl,
  output logic        MemtoReg,
  output logic        PCSrc,
  output logic        MemWrite,
  output logic        mem_req,
  output logic        pc_en,
  output logic        writeData3Src,
  output logic        srcASrc,
  output logic [3:0]  flags,
  output logic        mem_err
);

  logic [1:0] op;
  logic [3:0] cond;
  logic [3:0] cmd;
  logic [3:0] rd;

  assign op   = instr[27:26];
  assign cond = instr[31:28];
  assign cmd  = instr[24:21];
  assign rd   = instr[15:12];

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_pass;

  sm_cond_check u_cond (
    .cond_i  (cond),
    .flags_i (flags_q),
    .pass_o  (cond_pass)
  );

  logic [1:0] dec_reg_src;
  logic       dec_reg_write;
  logic [1:0] dec_imm_src;
  logic       dec_alu_src;
  logic [1:0] dec_alu_ctl;
  logic       dec_mem_to_reg;
  logic       dec_branch;
  logic       dec_mem_write;
  logic       dec_mem;
  logic       dec_ldr;
  logic       dec_link;
  logic       dec_src_a;
  logic       dec_flag_we;
  logic       dec_flag_all;

  always_comb begin
    dec_reg_src    = 2'b00;
    dec_reg_write  = 1'b0;
    dec_imm_src    = IMM_DP;
    dec_alu_src    = 1'b0;
    dec_alu_ctl    = ALU_ADD;
    dec_mem_to_reg = 1'b0;
    dec_branch     = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem        = 1'b0;
    dec_ldr        = 1'b0;
    dec_link       = 1'b0;
    dec_src_a      = 1'b0;
    dec_flag_we    = 1'b0;
    dec_flag_all   = 1'b0;
    case (op)
      DP: begin
        dec_alu_src  = instr[25];
        dec_flag_all = cmd_is_arith(cmd);
        unique case (1'b1)
          cmd == CMD_ADD: begin
            dec_alu_ctl   = ALU_ADD;
            dec_reg_write = 1'b1;
            dec_flag_we   = instr[20];
          end
          cmd == CMD_SUB: begin
            dec_alu_ctl   = ALU_SUB;
            dec_reg_write = 1'b1;
            dec_flag_we   = instr[20];
          end
          cmd == CMD_AND: begin
            dec_alu_ctl   = ALU_AND;
            dec_reg_write = 1'b1;
            dec_flag_we   = instr[20];
          end
          cmd == CMD_ORR: begin
            dec_alu_ctl   = ALU_ORR;
            dec_reg_write = 1'b1;
            dec_flag_we   = instr[20];
          end
          cmd == CMD_CMP: begin
            dec_alu_ctl = ALU_SUB;
            dec_flag_we = 1'b1;
          end
          cmd == CMD_MOV: begin
            dec_alu_ctl   = ALU_ADD;
            dec_src_a     = 1'b1;
            dec_reg_write = 1'b1;
            dec_flag_we   = instr[20];
          end
          default: ;
        endcase
      end
      MEM: begin
        dec_mem     = 1'b1;
        dec_alu_src = 1'b1;
        dec_imm_src = IMM_MEM;
        dec_alu_ctl = instr[23] ? ALU_ADD : ALU_SUB;
        if (instr[20]) begin
          dec_ldr        = 1'b1;
          dec_mem_to_reg = 1'b1;
        end else begin
          dec_reg_src[1] = 1'b1;
          dec_mem_write  = 1'b1;
        end
      end
      BR: begin
        dec_reg_src[0] = 1'b1;
        dec_alu_src    = 1'b1;
        dec_imm_src    = IMM_BR;
        dec_alu_ctl    = ALU_ADD;
        dec_branch     = 1'b1;
        dec_link       = instr[24];
        dec_reg_write  = instr[24];
      end
      default: ;
    endcase
  end

  logic dp_pc;
  logic ldr_pc;

  assign dp_pc  = (op == DP) && dec_reg_write && (rd == PC_REG);
  assign ldr_pc = dec_ldr && (rd == PC_REG);

  assign flags_d = {alu_flags[3:2],
                    dec_flag_all ? alu_flags[1:0] : flags_q[1:0]};

`ifdef SM_MEM_WAIT_EN
  localparam int CW = $clog2(MEM_WAIT_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  logic rw_c, mw_c, req_c, pcs_c, pce_c, fupd_c, err_c;

  always_comb begin
    state_d = state_q;
    rw_c    = 1'b0;
    mw_c    = 1'b0;
    req_c   = 1'b0;
    pcs_c   = 1'b0;
    pce_c   = 1'b0;
    fupd_c  = 1'b0;
    err_c   = 1'b0;
`ifdef SM_MEM_WAIT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      EXEC: begin
        if (!cond_pass) begin
          pce_c = 1'b1;
        end else if (dec_mem) begin
          req_c = 1'b1;
          mw_c  = dec_mem_write;
          if (mem_ack) begin
            pce_c = 1'b1;
            rw_c  = dec_ldr;
            pcs_c = ldr_pc;
          end else begin
            state_d = WAIT;
`ifdef SM_MEM_WAIT_EN
            cnt_d   = CW'(1);
`endif
          end
        end else begin
          pce_c  = 1'b1;
          rw_c   = dec_reg_write;
          pcs_c  = dec_branch | dp_pc;
          fupd_c = dec_flag_we;
        end
      end
      WAIT: begin
        req_c = 1'b1;
        mw_c  = dec_mem_write;
        if (mem_ack) begin
          pce_c   = 1'b1;
          rw_c    = dec_ldr;
          pcs_c   = ldr_pc;
          state_d = EXEC;
`ifdef SM_MEM_WAIT_EN
        end else if (cnt_q == CW'(MEM_WAIT_MAX)) begin
          // Abandon the access: retire without writeback.
          err_c   = 1'b1;
          pce_c   = 1'b1;
          state_d = EXEC;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
    endcase
    if (rst_p) begin
      rw_c   = 1'b0;
      mw_c   = 1'b0;
      req_c  = 1'b0;
      pcs_c  = 1'b0;
      pce_c  = 1'b0;
      fupd_c = 1'b0;
      err_c  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state_q <= EXEC;
      flags_q <= 4'b0000;
`ifdef SM_MEM_WAIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (fupd_c) flags_q <= flags_d;
`ifdef SM_MEM_WAIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign RegSrc        = dec_reg_src;
  assign RegWrite      = rw_c;
  assign ImmSrc        = dec_imm_src;
  assign ALUSrc        = dec_alu_src;
  assign ALUControl    = dec_alu_ctl;
  assign MemtoReg      = dec_mem_to_reg;
  assign PCSrc         = pcs_c;
  assign MemWrite      = mw_c;
  assign mem_req       = req_c;
  assign pc_en         = pce_c;
  assign writeData3Src = dec_link;
  assign srcASrc       = dec_src_a;
  assign flags         = flags_q;

`ifdef SM_MEM_WAIT_EN
  assign mem_err = err_c;
`else
  logic        unused_err;
  logic [31:0] unused_max;
  assign mem_err    = 1'b0;
  assign unused_err = err_c;
  assign unused_max = MEM_WAIT_MAX;
`endif

  logic unused_bits;
  assign unused_bits = ^{instr[22], instr[19:16], instr[11:0]};

endmodule

// File: tb/tb_sm_control_unit.sv
// Directed self-checking bench for sm_control_unit.
// Inputs change 1 unit after posedge; outputs sampled 1 unit later.
module tb_sm_control_unit;

  logic        clk = 1'b0;
  logic        rst_p;
  logic [31:0] instr;
  logic [3:0]  alu_flags;
  logic        mem_ack;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic [1:0]  ImmSrc;
  logic        ALUSrc;
  logic [1:0]  ALUControl;
  logic        MemtoReg;
  logic        PCSrc;
  logic        MemWrite;
  logic        mem_req;
  logic        pc_en;
  logic        writeData3Src;
  logic        srcASrc;
  logic [3:0]  flags;
  logic        mem_err;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sm_control_unit dut (
    .clk           (clk),
    .rst_p         (rst_p),
    .instr         (instr),
    .alu_flags     (alu_flags),
    .mem_ack       (mem_ack),
    .RegSrc        (RegSrc),
    .RegWrite      (RegWrite),
    .ImmSrc        (ImmSrc),
    .ALUSrc        (ALUSrc),
    .ALUControl    (ALUControl),
    .MemtoReg      (MemtoReg),
    .PCSrc         (PCSrc),
    .MemWrite      (MemWrite),
    .mem_req       (mem_req),
    .pc_en         (pc_en),
    .writeData3Src (writeData3Src),
    .srcASrc       (srcASrc),
    .flags         (flags),
    .mem_err       (mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [3:0] f,
                       input logic a);
    instr     = i;
    alu_flags = f;
    mem_ack   = a;
    #1;
  endtask

  localparam logic [31:0] I_ADDS  = 32'hE2921005;
  localparam logic [31:0] I_BEQ   = 32'h0A000002;
  localparam logic [31:0] I_BL    = 32'hEB000004;
  localparam logic [31:0] I_LDR   = 32'hE5910004;
  localparam logic [31:0] I_LDREQ = 32'h05910004;
  localparam logic [31:0] I_STR   = 32'hE5810000;
  localparam logic [31:0] I_MOV   = 32'hE3A030FF;
  localparam logic [31:0] I_CMP   = 32'hE3510000;
  localparam logic [31:0] I_ORRS  = 32'hE3911001;
  localparam logic [31:0] I_NVADD = 32'hF2921005;

  initial begin
    rst_p = 1'b1;
    drive(I_ADDS, 4'b0100, 1'b0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_pcsrc", PCSrc, 0);
    chk("rst_flags", flags, 4'b0000);
    chk("rst_mem_err", mem_err, 0);
    nxt();
    rst_p = 1'b0;

    drive(I_LDREQ, 4'b0000, 1'b0);
    chk("ldreq_fail_req", mem_req, 0);
    chk("ldreq_fail_pc_en", pc_en, 1);
    chk("ldreq_fail_rw", RegWrite, 0);
    nxt();

    drive(I_ADDS, 4'b0100, 1'b0);
    chk("adds_rw", RegWrite, 1);
    chk("adds_alusrc", ALUSrc, 1);
    chk("adds_aluctl", ALUControl, 2'b00);
    chk("adds_immsrc", ImmSrc, 2'b00);
    chk("adds_pc_en", pc_en, 1);
    nxt();
    chk("adds_flags", flags, 4'b0100);

    drive(I_BEQ, 4'b0000, 1'b0);
    chk("beq_t_pcsrc", PCSrc, 1);
    chk("beq_t_regsrc", RegSrc, 2'b01);
    chk("beq_t_immsrc", ImmSrc, 2'b10);
    chk("beq_t_rw", RegWrite, 0);
    nxt();
    chk("beq_t_flags", flags, 4'b0100);

    drive(I_MOV, 4'b1000, 1'b0);
    chk("mov_srca", srcASrc, 1);
    chk("mov_aluctl", ALUControl, 2'b00);
    chk("mov_rw", RegWrite, 1);
    nxt();
    chk("mov_flags", flags, 4'b0100);

    drive(I_CMP, 4'b0110, 1'b0);
    chk("cmp_rw", RegWrite, 0);
    chk("cmp_aluctl", ALUControl, 2'b01);
    nxt();
    chk("cmp_flags", flags, 4'b0110);

    drive(I_ORRS, 4'b1001, 1'b0);
    chk("orrs_aluctl", ALUControl, 2'b11);
    nxt();
    chk("orrs_flags_nz", flags, 4'b1010);

    drive(I_BEQ, 4'b0000, 1'b0);
    chk("beq_f_pcsrc", PCSrc, 0);
    chk("beq_f_rw", RegWrite, 0);
    chk("beq_f_pc_en", pc_en, 1);
    nxt();

    drive(I_BL, 4'b0000, 1'b0);
    chk("bl_wd3", writeData3Src, 1);
    chk("bl_rw", RegWrite, 1);
    chk("bl_pcsrc", PCSrc, 1);
    chk("bl_alusrc", ALUSrc, 1);
    nxt();

    drive(I_NVADD, 4'b1111, 1'b0);
    chk("nv_rw", RegWrite, 0);
    chk("nv_pc_en", pc_en, 1);
    nxt();
    chk("nv_flags", flags, 4'b1010);

    drive(I_LDR, 4'b0000, 1'b0);
    chk("ldr_immsrc", ImmSrc, 2'b01);
    chk("ldr_aluctl", ALUControl, 2'b00);
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("ldr_w%0d_req", i), mem_req, 1);
      chk($sformatf("ldr_w%0d_pc_en", i), pc_en, 0);
      chk($sformatf("ldr_w%0d_rw", i), RegWrite, 0);
      nxt();
    end
    drive(I_LDR, 4'b0000, 1'b1);
    chk("ldr_ack_req", mem_req, 1);
    chk("ldr_ack_rw", RegWrite, 1);
    chk("ldr_ack_mtr", MemtoReg, 1);
    chk("ldr_ack_pc_en", pc_en, 1);
    nxt();

    drive(I_LDR, 4'b0000, 1'b0);
    nxt();
`ifdef SM_MEM_WAIT_EN
    for (int i = 1; i < 15; i++) begin
      chk($sformatf("to_w%0d_err", i), mem_err, 0);
      chk($sformatf("to_w%0d_pc_en", i), pc_en, 0);
      nxt();
    end
    chk("to_err_pulse", mem_err, 1);
    chk("to_pc_en", pc_en, 1);
    chk("to_rw", RegWrite, 0);
    nxt();
    drive(I_MOV, 4'b0000, 1'b0);
    chk("to_after_err", mem_err, 0);
    chk("to_after_req", mem_req, 0);
    nxt();
`else
    for (int i = 1; i <= 20; i++) begin
      chk($sformatf("lw_%0d_pc_en", i), pc_en, 0);
      chk($sformatf("lw_%0d_err", i), mem_err, 0);
      nxt();
    end
    drive(I_LDR, 4'b0000, 1'b1);
    chk("lw_ack_pc_en", pc_en, 1);
    nxt();
`endif

    drive(I_STR, 4'b0000, 1'b0);
    chk("str_regsrc", RegSrc, 2'b10);
    chk("str_memwrite", MemWrite, 1);
    nxt();
    chk("str_wait_req", mem_req, 1);
    chk("str_wait_mw", MemWrite, 1);
    chk("str_wait_pc_en", pc_en, 0);
    #2;
    rst_p = 1'b1;
    #1;
    chk("str_rst_req", mem_req, 0);
    chk("str_rst_mw", MemWrite, 0);
    chk("str_rst_pc_en", pc_en, 0);
    chk("str_rst_flags", flags, 4'b0000);
    nxt();
    rst_p = 1'b0;
    drive(I_MOV, 4'b0000, 1'b0);
    chk("post_rst_req", mem_req, 0);
    chk("post_rst_pc_en", pc_en, 1);
    chk("post_rst_rw", RegWrite, 1);
    nxt();
    drive(I_STR, 4'b0000, 1'b1);
    chk("post_rst_str_req", mem_req, 1);
    chk("post_rst_str_pc_en", pc_en, 1);
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
